// File: rtl/axi4_write_slave_mem.sv
// AXI4 write-channel slave terminating AW/W/B bursts into a word-addressed memory,
// with a registered side read port for inspecting stored words.
module axi4_write_slave_mem #(
  parameter int                            C_S_AXI_ADDR_WIDTH = 32,
  parameter int                            C_S_AXI_DATA_WIDTH = 32,
  parameter int                            MEM_DEPTH_WORDS    = 1024,
  parameter logic [C_S_AXI_ADDR_WIDTH-1:0] BASE_ADDR          = '0
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s_axi_awaddr,
  input  logic [7:0]                        s_axi_awlen,
  input  logic [2:0]                        s_axi_awsize,
  input  logic [1:0]                        s_axi_awburst,
  input  logic                              s_axi_awvalid,
  output logic                              s_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     s_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   s_axi_wstrb,
  input  logic                              s_axi_wlast,
  input  logic                              s_axi_wvalid,
  output logic                              s_axi_wready,
  output logic [1:0]                        s_axi_bresp,
  output logic                              s_axi_bvalid,
  input  logic                              s_axi_bready,
  input  logic [$clog2(MEM_DEPTH_WORDS)-1:0] i_rd_addr,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     o_rd_data,
  output logic                              o_busy,
  output logic [15:0]                       o_burst_count
);

  localparam int IDX_W  = $clog2(MEM_DEPTH_WORDS);
  localparam int NBYTES = C_S_AXI_DATA_WIDTH / 8;
  localparam logic [C_S_AXI_ADDR_WIDTH-1:0] DEPTH = C_S_AXI_ADDR_WIDTH'(MEM_DEPTH_WORDS);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_W_DATA = 2'd1;
  localparam logic [1:0] S_B_RESP = 2'd2;

  logic [1:0]                    state;
  logic [C_S_AXI_ADDR_WIDTH-1:0] idx;
  logic [7:0]                    len;
  logic [7:0]                    beat_cnt;
  logic                          fixed;
  logic                          attr_err;
  logic                          resp_err;

  logic [C_S_AXI_DATA_WIDTH-1:0] mem [MEM_DEPTH_WORDS];

  logic aw_hs, w_hs, b_hs, in_range, last_cnt, burst_end, mem_we, bad_attr;

  // Ready/valid outputs depend only on state, never on the matching valid.
  assign s_axi_awready = (state == S_IDLE) && !reset;
  assign s_axi_wready  = (state == S_W_DATA);
  assign s_axi_bvalid  = (state == S_B_RESP);
  assign s_axi_bresp   = {s_axi_bvalid && resp_err, 1'b0};
  assign o_busy        = (state != S_IDLE);

  assign aw_hs     = s_axi_awvalid && s_axi_awready;
  assign w_hs      = s_axi_wvalid && s_axi_wready;
  assign b_hs      = s_axi_bvalid && s_axi_bready;
  assign in_range  = (idx < DEPTH);
  assign last_cnt  = (beat_cnt == len);
  assign burst_end = w_hs && (s_axi_wlast || last_cnt);
  assign bad_attr  = (s_axi_awsize != 3'b010) || s_axi_awburst[1];
  // Only bad AW attributes block writes; an out-of-range beat poisons the
  // response but later in-range beats of the same burst still land.
  assign mem_we    = w_hs && !attr_err && in_range && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      idx           <= '0;
      len           <= '0;
      beat_cnt      <= '0;
      fixed         <= 1'b0;
      attr_err      <= 1'b0;
      resp_err      <= 1'b0;
      o_burst_count <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (aw_hs) begin
            idx      <= (s_axi_awaddr - BASE_ADDR) >> 2;
            len      <= s_axi_awlen;
            fixed    <= (s_axi_awburst == 2'b00);
            beat_cnt <= '0;
            attr_err <= bad_attr;
            resp_err <= bad_attr;
            state    <= S_W_DATA;
          end
        end
        S_W_DATA: begin
          if (w_hs) begin
            if (!fixed) idx <= idx + 1'b1;
            beat_cnt <= beat_cnt + 8'd1;
            if (!in_range || (s_axi_wlast != last_cnt)) resp_err <= 1'b1;
            if (burst_end) state <= S_B_RESP;
          end
        end
        S_B_RESP: begin
          if (b_hs) begin
            o_burst_count <= o_burst_count + 16'd1;
            state         <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Memory contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < NBYTES; b++) begin
        if (s_axi_wstrb[b]) mem[idx[IDX_W-1:0]][8*b +: 8] <= s_axi_wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) o_rd_data <= '0;
    else       o_rd_data <= mem[i_rd_addr];
  end

endmodule

// File: tb/tb_axi4_write_slave_mem.sv
// Bench for axi4_write_slave_mem: table of bursts with a bresp scoreboard,
// side-port readback table, and hand sequences for reset mid-burst and early W.
module tb_axi4_write_slave_mem;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] s_axi_awaddr;
  logic [7:0]  s_axi_awlen;
  logic [2:0]  s_axi_awsize;
  logic [1:0]  s_axi_awburst;
  logic        s_axi_awvalid;
  logic        s_axi_awready;
  logic [31:0] s_axi_wdata;
  logic [3:0]  s_axi_wstrb;
  logic        s_axi_wlast;
  logic        s_axi_wvalid;
  logic        s_axi_wready;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid;
  logic        s_axi_bready;
  logic [9:0]  i_rd_addr;
  logic [31:0] o_rd_data;
  logic        o_busy;
  logic [15:0] o_burst_count;

  always #5 clk = ~clk;

  axi4_write_slave_mem dut (
    .clk(clk), .reset(reset),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen), .s_axi_awsize(s_axi_awsize),
    .s_axi_awburst(s_axi_awburst), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .i_rd_addr(i_rd_addr), .o_rd_data(o_rd_data), .o_busy(o_busy), .o_burst_count(o_burst_count)
  );

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [31:0] data;
    logic [3:0]  strb;
    int          wlast_at;
    int          bdelay;
    logic [1:0]  resp;
  } burst_t;

  typedef struct {
    logic [9:0]  a;
    logic [31:0] d;
  } rd_t;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [15:0] exp_count = 16'd0;
  logic [1:0]  resp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_aw();
    int n = 0;
    while (!s_axi_awready && n < 50) begin tick(); n++; end
    if (!s_axi_awready) chk("aw_timeout", 32'(s_axi_awready), 32'd1);
    tick();
  endtask

  task automatic wait_w();
    int n = 0;
    while (!s_axi_wready && n < 50) begin tick(); n++; end
    if (!s_axi_wready) chk("w_timeout", 32'(s_axi_wready), 32'd1);
    tick();
  endtask

  task automatic run_burst(input burst_t b);
    int  beat;
    bit  done;
    logic [1:0] exp_resp;
    s_axi_awaddr  = b.addr;
    s_axi_awlen   = b.len;
    s_axi_awsize  = b.size;
    s_axi_awburst = b.burst;
    s_axi_awvalid = 1'b1;
    resp_q.push_back(b.resp);
    wait_aw();
    s_axi_awvalid = 1'b0;
    chk("aw_to_wready", 32'(s_axi_wready), 32'd1);
    beat = 0;
    done = 1'b0;
    while (!done) begin
      s_axi_wvalid = 1'b1;
      s_axi_wdata  = b.data + 32'(beat);
      s_axi_wstrb  = b.strb;
      s_axi_wlast  = (beat == b.wlast_at);
      wait_w();
      done = (beat == b.wlast_at) || (beat == int'(b.len));
      beat++;
    end
    s_axi_wvalid = 1'b0;
    s_axi_wlast  = 1'b0;
    chk("last_w_wready", 32'(s_axi_wready), 32'd0);
    chk("last_w_bvalid", 32'(s_axi_bvalid), 32'd1);
    for (int i = 0; i < b.bdelay; i++) begin
      chk("hold_bvalid", 32'(s_axi_bvalid), 32'd1);
      chk("hold_bresp", 32'(s_axi_bresp), 32'(b.resp));
      chk("hold_awready", 32'(s_axi_awready), 32'd0);
      tick();
    end
    s_axi_bready = 1'b1;
    exp_resp = resp_q.pop_front();
    chk("bresp", 32'(s_axi_bresp), 32'(exp_resp));
    tick();
    s_axi_bready = 1'b0;
    exp_count = exp_count + 16'd1;
    chk("b_to_awready", 32'(s_axi_awready), 32'd1);
    chk("b_bvalid_low", 32'(s_axi_bvalid), 32'd0);
    chk("burst_count", 32'(o_burst_count), 32'(exp_count));
  endtask

  task automatic rd_chk(input logic [9:0] a, input logic [31:0] d);
    i_rd_addr = a;
    tick();
    chk($sformatf("mem[%0d]", a), o_rd_data, d);
  endtask

  burst_t vec[13];
  rd_t    rdv[17];

  initial begin
    vec = '{
      '{32'h0000_0000, 8'd0, 3'b010, 2'b01, 32'hFFFF_FFFF, 4'hF, 0, 0, 2'b00},
      '{32'h0000_0004, 8'd0, 3'b010, 2'b01, 32'h1111_1111, 4'hF, 0, 0, 2'b00},
      '{32'h0000_0040, 8'd1, 3'b010, 2'b01, 32'h5A5A_0000, 4'hF, 1, 0, 2'b00},
      '{32'h0000_0050, 8'd1, 3'b010, 2'b01, 32'h6B6B_0000, 4'hF, 1, 2, 2'b00},
      '{32'h0000_0010, 8'd3, 3'b010, 2'b01, 32'h0000_00A0, 4'hF, 3, 0, 2'b00},
      '{32'h0000_0000, 8'd0, 3'b010, 2'b01, 32'h1234_5678, 4'b0101, 0, 0, 2'b00},
      '{32'h0000_0FF8, 8'd3, 3'b010, 2'b01, 32'h0000_00B0, 4'hF, 3, 0, 2'b10},
      '{32'h0000_0040, 8'd1, 3'b011, 2'b01, 32'h0000_00C0, 4'hF, 1, 0, 2'b10},
      '{32'h0000_0050, 8'd1, 3'b010, 2'b10, 32'h0000_00D0, 4'hF, 1, 0, 2'b10},
      '{32'h0000_0060, 8'd3, 3'b010, 2'b01, 32'h0000_0060, 4'hF, 1, 5, 2'b10},
      '{32'h0000_0080, 8'd2, 3'b010, 2'b00, 32'h0000_00E0, 4'hF, 2, 0, 2'b00},
      '{32'h0000_0090, 8'd1, 3'b010, 2'b01, 32'h0000_0090, 4'hF, 5, 0, 2'b10},
      '{32'h0000_0008, 8'd0, 3'b010, 2'b01, 32'h0000_0002, 4'hF, 0, 1, 2'b00}
    };
    rdv = '{
      '{10'd4,    32'h0000_00A0}, '{10'd5,    32'h0000_00A1},
      '{10'd6,    32'h0000_00A2}, '{10'd7,    32'h0000_00A3},
      '{10'd0,    32'hFF34_FF78}, '{10'd1,    32'h1111_1111},
      '{10'd1022, 32'h0000_00B0}, '{10'd1023, 32'h0000_00B1},
      '{10'd16,   32'h5A5A_0000}, '{10'd17,   32'h5A5A_0001},
      '{10'd20,   32'h6B6B_0000}, '{10'd21,   32'h6B6B_0001},
      '{10'd24,   32'h0000_0060}, '{10'd25,   32'h0000_0061},
      '{10'd32,   32'h0000_00E2}, '{10'd36,   32'h0000_0090},
      '{10'd37,   32'h0000_0091}
    };

    reset = 1'b1;
    s_axi_awaddr = '0; s_axi_awlen = '0; s_axi_awsize = 3'b010; s_axi_awburst = 2'b01;
    s_axi_awvalid = 1'b0; s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wlast = 1'b0;
    s_axi_wvalid = 1'b0; s_axi_bready = 1'b0; i_rd_addr = '0;
    tick(); tick(); tick();
    chk("rst_awready", 32'(s_axi_awready), 32'd0);
    chk("rst_wready", 32'(s_axi_wready), 32'd0);
    chk("rst_bvalid", 32'(s_axi_bvalid), 32'd0);
    chk("rst_rd_data", o_rd_data, 32'd0);
    reset = 1'b0;
    tick();
    chk("post_rst_awready", 32'(s_axi_awready), 32'd1);
    chk("post_rst_busy", 32'(o_busy), 32'd0);
    chk("post_rst_count", 32'(o_burst_count), 32'd0);
    chk("post_rst_bresp", 32'(s_axi_bresp), 32'd0);

    for (int i = 0; i < 13; i++) run_burst(vec[i]);
    for (int i = 0; i < 17; i++) rd_chk(rdv[i].a, rdv[i].d);

    // Reset in the middle of a len-7 burst after two accepted beats.
    s_axi_awaddr = 32'h0000_00A0; s_axi_awlen = 8'd7; s_axi_awsize = 3'b010;
    s_axi_awburst = 2'b01; s_axi_awvalid = 1'b1;
    wait_aw();
    s_axi_awvalid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      s_axi_wvalid = 1'b1; s_axi_wdata = 32'h7700_0000 + 32'(i);
      s_axi_wstrb = 4'hF; s_axi_wlast = 1'b0;
      wait_w();
    end
    s_axi_wvalid = 1'b0;
    chk("mid_busy", 32'(o_busy), 32'd1);
    reset = 1'b1;
    tick();
    chk("mid_rst_awready", 32'(s_axi_awready), 32'd0);
    chk("mid_rst_wready", 32'(s_axi_wready), 32'd0);
    chk("mid_rst_bvalid", 32'(s_axi_bvalid), 32'd0);
    chk("mid_rst_bresp", 32'(s_axi_bresp), 32'd0);
    chk("mid_rst_busy", 32'(o_busy), 32'd0);
    chk("mid_rst_count", 32'(o_burst_count), 32'd0);
    chk("mid_rst_rd_data", o_rd_data, 32'd0);
    reset = 1'b0;
    exp_count = 16'd0;
    tick();
    chk("mid_post_awready", 32'(s_axi_awready), 32'd1);

    // W presented before AW must stall, then land once AW is taken.
    s_axi_wvalid = 1'b1; s_axi_wdata = 32'h0000_0099; s_axi_wstrb = 4'hF; s_axi_wlast = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("early_w_stall", 32'(s_axi_wready), 32'd0);
      tick();
    end
    run_burst('{32'h0000_0024, 8'd0, 3'b010, 2'b01, 32'h0000_0099, 4'hF, 0, 0, 2'b00});

    rd_chk(10'd40, 32'h7700_0000);
    rd_chk(10'd41, 32'h7700_0001);
    rd_chk(10'd9,  32'h0000_0099);
    rd_chk(10'd2,  32'h0000_0002);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
